// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller: turns MEM-stage load/store requests into a single
// outstanding req/ack bus transaction, stalling the pipeline until it completes.
//   state | meaning
//   IDLE  | evaluate MEM-stage access, launch bus request if legal and aligned
//   BUSY  | bus_req held, waiting for bus_ack or timeout
//   DONE  | result presented on ReadDataM, pipeline released
module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  input  logic        MemReadM,
  input  logic [2:0]  Funct3M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        req_q, we_q, berr_q;
  logic [29:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q, rdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;

  logic        access, legal, aligned, ok, bad;
  logic [3:0]  wstrb_d;
  logic [31:0] wdata_d, load_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        start, ack_done, tmo, stall_raw, mis_raw;

  always_comb begin
    access = MemWriteM | MemReadM;
    legal  = 1'b0;
    if (MemWriteM) begin
      legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);
    end else begin
      legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010) ||
              (Funct3M == 3'b100) || (Funct3M == 3'b101);
    end
    case (Funct3M[1:0])
      2'b01:   aligned = ~ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
    ok  = access & legal & aligned;
    bad = access & ~(legal & aligned);
  end

  always_comb begin
    wstrb_d = 4'b0000;
    wdata_d = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        wstrb_d = 4'b0001 << ALUResultM[1:0];
        wdata_d = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        wstrb_d = ALUResultM[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{WriteDataM[15:0]}};
      end
      default: wstrb_d = 4'b1111;
    endcase
    if (!MemWriteM) wstrb_d = 4'b0000;
  end

  always_comb begin
    case (off_q)
      2'd0:    byte_sel = bus_rdata[7:0];
      2'd1:    byte_sel = bus_rdata[15:8];
      2'd2:    byte_sel = bus_rdata[23:16];
      default: byte_sel = bus_rdata[31:24];
    endcase
    half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'd0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'd0, half_sel};
      default: load_data = bus_rdata;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    ack_done  = 1'b0;
    tmo       = 1'b0;
    stall_raw = 1'b0;
    mis_raw   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ok) begin
          stall_raw = 1'b1;
          start     = 1'b1;
          state_d   = S_BUSY;
        end else if (bad) begin
          mis_raw = 1'b1;
        end
      end
      S_BUSY: begin
        stall_raw = 1'b1;
        if (bus_ack) begin
          ack_done = 1'b1;
          state_d  = S_DONE;
        end else if (cnt_q == 8'd0) begin
          tmo     = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Combinational outputs are gated so nothing escapes while reset is held.
  assign StallM    = reset & stall_raw;
  assign MisalignM = reset & mis_raw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      berr_q  <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      berr_q  <= tmo;
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= MemWriteM;
        addr_q  <= ALUResultM[31:2];
        wstrb_q <= wstrb_d;
        wdata_q <= wdata_d;
        f3_q    <= Funct3M;
        off_q   <= ALUResultM[1:0];
        cnt_q   <= TMO_LOAD;
      end else if (state_q == S_BUSY) begin
        if (ack_done) begin
          req_q   <= 1'b0;
          rdata_q <= we_q ? 32'd0 : load_data;
        end else if (tmo) begin
          req_q   <= 1'b0;
          rdata_q <= 32'd0;
        end else begin
          cnt_q <= cnt_q - 8'd1;
        end
      end
    end
  end

  assign ReadDataM = rdata_q;
  assign BusErrM   = berr_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wstrb = wstrb_q;
  assign bus_wdata = wdata_q;

endmodule
